// File: rtl/kmap_sweep_checker.sv
// Sweeps {A,B,C,D} through 0..15 and checks F_0..F_2 against expected truth tables (F_2 masked by a care mask).
// Latency 16*(SETTLE_CYC+1) cycles start->done; start is ignored unless idle; no backpressure.
module kmap_sweep_checker #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter logic [15:0] EXP_F0     = 16'h6996,
    parameter logic [15:0] EXP_F1     = 16'hEDE0,
    parameter logic [15:0] EXP_F2     = 16'hD1CC,
    parameter logic [15:0] CARE_F2    = 16'hDDDD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    input  logic       F_0,
    input  logic       F_1,
    input  logic       F_2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_cnt,
    output logic [3:0] first_fail_idx,
    output logic [2:0] first_fail_vec
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [6:0] ERR_MAX     = 7'd48;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] abcd_q, abcd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [5:0] err_q, err_d;
    logic [3:0] ffi_q, ffi_d;
    logic [2:0] ffv_q, ffv_d;
    logic [2:0] mm;
    logic [6:0] err_sum;
    logic [5:0] err_next;

    always_comb begin
        mm       = {(F_2 ^ EXP_F2[idx_q]) & CARE_F2[idx_q],
                    F_1 ^ EXP_F1[idx_q],
                    F_0 ^ EXP_F0[idx_q]};
        err_sum  = {1'b0, err_q} + {6'b0, mm[0]} + {6'b0, mm[1]} + {6'b0, mm[2]};
        err_next = (err_sum > ERR_MAX) ? ERR_MAX[5:0] : err_sum[5:0];
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        abcd_d   = abcd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        ffi_d    = ffi_q;
        ffv_d    = ffv_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    idx_d    = 4'd0;
                    abcd_d   = 4'd0;
                    settle_d = SETTLE_LOAD;
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    err_d    = 6'd0;
                    ffi_d    = 4'd0;
                    ffv_d    = 3'd0;
                end
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) state_d = S_CHECK;
                else                  settle_d = settle_q - 4'd1;
            end
            S_CHECK: begin
                err_d = err_next;
                // A zero error count means no earlier vector in this sweep has failed.
                if (err_q == 6'd0 && mm != 3'd0) begin
                    ffi_d = idx_q;
                    ffv_d = mm;
                end
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                    abcd_d  = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == 6'd0);
                end else begin
                    state_d  = S_SETTLE;
                    idx_d    = idx_q + 4'd1;
                    abcd_d   = idx_q + 4'd1;
                    settle_d = SETTLE_LOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            settle_q <= 4'd0;
            abcd_q   <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 6'd0;
            ffi_q    <= 4'd0;
            ffv_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            abcd_q   <= abcd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffi_q    <= ffi_d;
            ffv_q    <= ffv_d;
        end
    end

    assign {A, B, C, D}   = abcd_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vec = ffv_q;
endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Bench for kmap_sweep_checker: a table-driven K-map responder with per-vector flip masks feeds two instances
// (SETTLE_CYC=1 and 3); expected results come from counting masked flips over the whole table.
module tb_kmap_sweep_checker;
    localparam logic [15:0] EXP0 = 16'h6996;
    localparam logic [15:0] EXP1 = 16'hEDE0;
    localparam logic [15:0] EXP2 = 16'hD1CC;
    localparam logic [15:0] CARE = 16'hDDDD;

    logic clk = 1'b0;
    logic rst_n;
    logic st;
    logic sel;

    logic start0, a0, b0, c0, d0, f00, f10, f20, busy0, done0, pass0;
    logic [5:0] err0;
    logic [3:0] ffi0;
    logic [2:0] ffv0;
    logic start1, a1, b1, c1, d1, f01, f11, f21, busy1, done1, pass1;
    logic [5:0] err1;
    logic [3:0] ffi1;
    logic [2:0] ffv1;

    logic [2:0] flip [16];
    logic [3:0] v0, v1;
    logic       m_busy, m_done, m_pass;
    logic [3:0] m_abcd, m_ffi;
    logic [5:0] m_err;
    logic [2:0] m_ffv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kmap_sweep_checker #(.SETTLE_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .A(a0), .B(b0), .C(c0), .D(d0),
        .F_0(f00), .F_1(f10), .F_2(f20),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_fail_idx(ffi0), .first_fail_vec(ffv0)
    );

    kmap_sweep_checker #(.SETTLE_CYC(3)) u_slow (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .A(a1), .B(b1), .C(c1), .D(d1),
        .F_0(f01), .F_1(f11), .F_2(f21),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail_idx(ffi1), .first_fail_vec(ffv1)
    );

    // Block under test: the correct K-map with a per-vector flip mask applied.
    assign v0  = {a0, b0, c0, d0};
    assign v1  = {a1, b1, c1, d1};
    assign f00 = EXP0[v0] ^ flip[v0][0];
    assign f10 = EXP1[v0] ^ flip[v0][1];
    assign f20 = EXP2[v0] ^ flip[v0][2];
    assign f01 = EXP0[v1] ^ flip[v1][0];
    assign f11 = EXP1[v1] ^ flip[v1][1];
    assign f21 = EXP2[v1] ^ flip[v1][2];

    assign start0 = st & ~sel;
    assign start1 = st & sel;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_abcd = sel ? v1 : v0;
    assign m_err  = sel ? err1 : err0;
    assign m_ffi  = sel ? ffi1 : ffi0;
    assign m_ffv  = sel ? ffv1 : ffv0;

    function automatic void model(output int err, output int ffi, output logic [2:0] ffv);
        logic [2:0] eff;
        bit found;
        err = 0; ffi = 0; ffv = 3'd0; found = 0;
        for (int i = 0; i < 16; i++) begin
            eff = {flip[i][2] & CARE[i], flip[i][1:0]};
            err += int'(eff[0]) + int'(eff[1]) + int'(eff[2]);
            if (!found && eff != 3'd0) begin
                found = 1; ffi = i; ffv = eff;
            end
        end
        if (err > 48) err = 48;
    endfunction

    task automatic set_flips(input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: flip[i] = 3'd0;
                1: flip[i] = {2'b00, EXP0[i]};
                2: flip[i] = {~CARE[i], 2'b00};
                3: flip[i] = 3'b111;
                4: flip[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                default: flip[i] = {~CARE[i] & 1'($urandom_range(0, 1)), 2'b00};
            endcase
        end
    endtask

    // One complete sweep on the selected instance; rp_a/rp_b are cycles at which start is re-pulsed.
    task automatic sweep(input string name, input int settle, input int rp_a, input int rp_b);
        int err, ffi, total;
        logic [2:0] ffv;
        model(err, ffi, ffv);
        total = 16 * (settle + 1);
        @(posedge clk); #1; st = 1'b1;
        @(posedge clk); #1; st = 1'b0;
        for (int c = 0; c <= total + 2; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            n_tests += 3;
            if (m_done !== (c == total)) begin
                n_fail++; $display("FAIL %s done c=%0d got %b exp %b", name, c, m_done, c == total);
            end
            if (m_busy !== (c < total)) begin
                n_fail++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, m_busy, c < total);
            end
            if (m_abcd !== ((c < total) ? 4'(c / (settle + 1)) : 4'd0)) begin
                n_fail++; $display("FAIL %s abcd c=%0d got %0d", name, c, m_abcd);
            end
            if (c < total) begin
                n_tests++;
                if (m_pass !== 1'b0) begin
                    n_fail++; $display("FAIL %s pass_mid c=%0d got %b exp 0", name, c, m_pass);
                end
            end else begin
                n_tests += 4;
                if (m_pass !== (err == 0)) begin
                    n_fail++; $display("FAIL %s pass c=%0d got %b exp %b", name, c, m_pass, err == 0);
                end
                if (m_err !== 6'(err)) begin
                    n_fail++; $display("FAIL %s err_cnt c=%0d got %0d exp %0d", name, c, m_err, err);
                end
                if (m_ffi !== 4'(ffi)) begin
                    n_fail++; $display("FAIL %s first_fail_idx got %0d exp %0d", name, m_ffi, ffi);
                end
                if (m_ffv !== ffv) begin
                    n_fail++; $display("FAIL %s first_fail_vec got %b exp %b", name, m_ffv, ffv);
                end
            end
            st = (c == rp_a || c == rp_b);
        end
        st = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st = 1'b1; sel = 1'b0; set_flips(0);
        repeat (3) @(posedge clk);
        #1;
        n_tests += 6;
        if ({busy0, done0, pass0} !== 3'b000) begin
            n_fail++; $display("FAIL reset flags0 got %b exp 000", {busy0, done0, pass0});
        end
        if ({busy1, done1, pass1} !== 3'b000) begin
            n_fail++; $display("FAIL reset flags1 got %b exp 000", {busy1, done1, pass1});
        end
        if (v0 !== 4'd0 || v1 !== 4'd0) begin
            n_fail++; $display("FAIL reset abcd got %0d/%0d exp 0", v0, v1);
        end
        if (err0 !== 6'd0 || err1 !== 6'd0) begin
            n_fail++; $display("FAIL reset err_cnt got %0d/%0d exp 0", err0, err1);
        end
        if (ffi0 !== 4'd0 || ffv0 !== 3'd0) begin
            n_fail++; $display("FAIL reset first_fail got %0d/%b exp 0/000", ffi0, ffv0);
        end
        st = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset start_ignored got busy %b exp 0", busy0);
        end
    endtask

    task automatic test_main();
        sel = 1'b0;
        set_flips(0); sweep("correct", 1, -1, -1);
        set_flips(1); sweep("f0_tied0", 1, -1, -1);
        set_flips(2); sweep("dontcare", 1, -1, -1);
    endtask

    task automatic test_restart_ignored();
        sel = 1'b0;
        set_flips(1); sweep("repulse", 1, 5, 20);
        set_flips(0); sweep("start_in_done", 1, 32, -1);
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_flips((k % 3 == 2) ? 5 : 4);
            sweep("random", 1, -1, -1);
        end
    endtask

    task automatic test_mid_reset();
        sel = 1'b0; set_flips(1);
        @(posedge clk); #1; st = 1'b1;
        @(posedge clk); #1; st = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        n_tests++;
        if (v0 !== 4'd7) begin
            n_fail++; $display("FAIL midreset idx got %0d exp 7", v0);
        end
        rst_n = 1'b0; st = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; st = 1'b0;
        n_tests += 3;
        if ({busy0, done0, pass0} !== 3'b000) begin
            n_fail++; $display("FAIL midreset flags got %b exp 000", {busy0, done0, pass0});
        end
        if (v0 !== 4'd0) begin
            n_fail++; $display("FAIL midreset abcd got %0d exp 0", v0);
        end
        if (err0 !== 6'd0 || ffi0 !== 4'd0 || ffv0 !== 3'd0) begin
            n_fail++; $display("FAIL midreset results got %0d/%0d/%b exp 0", err0, ffi0, ffv0);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++; $display("FAIL midreset quiet c=%0d got done %b busy %b exp 0 0", c, done0, busy0);
            end
        end
        set_flips(4); sweep("after_reset", 1, -1, -1);
    endtask

    task automatic test_slow_inverted();
        sel = 1'b1;
        set_flips(3); sweep("slow_inverted", 3, -1, -1);
        set_flips(4); sweep("slow_random", 3, 10, -1);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        set_flips(4); sweep("b2b_a", 1, -1, -1);
        set_flips(0); sweep("b2b_b", 1, -1, -1);
    endtask

    initial begin
        rst_n = 1'b0; st = 1'b0; sel = 1'b0;
        test_reset();
        test_main();
        test_restart_ignored();
        test_random();
        test_mid_reset();
        test_slow_inverted();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
